mem_block_copy: RTL and testbench

Bus-master block-copy engine that drives the single-port data memory interface (10-bit word address, 16-bit data, write enable, combinational read data) from the initiator side. On a start request it copies `len` 16-bit words from a source region to a destination region through that port, choosing the copy direction so overlapping regions are copied correctly. It accumulates a 16-bit checksum of the words moved and reports completion with a one-cycle pulse. It sits beside the CPU datapath and owns the memory port while busy; the port mux outside this block selects it whenever `busy` is high.

---
 rtl/mem_block_copy.sv | 170 +++++++++++++++++
 tb/tb_mem_block_copy.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_copy.sv
// rtl/mem_block_copy.sv - memory-to-memory block copy engine with overlap-safe direction
//
// Copies len words from src to dst through the single-port data memory, two
// cycles per word (READ then WRITE), and accumulates a mod-2^DW sum of the
// words read. The copy runs descending when dst > src so that an overlapping
// destination never overwrites source words before they are read.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         copy request, sampled only in IDLE
//   src, dst, len first source address, first destination address, word count
//   busy          high in READ and WRITE (memory port owned by this block)
//   done          one-cycle completion pulse
//   sum           sum of the words read by the last copy
//   adr           memory word address
//   data          memory write data
//   memwen        memory write enable
//   resMem        memory read data, combinational from adr

module mem_block_copy #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] data,
  output logic          memwen,
  input  logic [DW-1:0] resMem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [AW-1:0] cnt;
  logic [DW-1:0] buf_q;
  logic          desc;

  // Start-time pointer setup; all arithmetic wraps modulo 2^AW.
  logic          start_desc;
  logic [AW-1:0] len_m1;
  logic [AW-1:0] src_first;
  logic [AW-1:0] dst_first;

  // Pointers after the current word, in the latched direction.
  logic [AW-1:0] src_next;
  logic [AW-1:0] dst_next;

  always_comb begin
    start_desc = (dst > src);
    len_m1     = len - ONE;
    src_first  = start_desc ? (src + len_m1) : src;
    dst_first  = start_desc ? (dst + len_m1) : dst;
    src_next   = desc ? (src_ptr - ONE) : (src_ptr + ONE);
    dst_next   = desc ? (dst_ptr - ONE) : (dst_ptr + ONE);
  end

  // Single state machine; every output is loaded with the value it must hold
  // in the state being entered, so all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      buf_q   <= '0;
      desc    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      adr     <= '0;
      data    <= '0;
      memwen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr <= src_first;
            dst_ptr <= dst_first;
            cnt     <= len;
            desc    <= start_desc;
            sum     <= '0;
            memwen  <= 1'b0;
            if (len == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              adr   <= '0;
              data  <= '0;
            end else begin
              state <= S_READ;
              busy  <= 1'b1;
              done  <= 1'b0;
              adr   <= src_first;
              data  <= buf_q;
            end
          end else begin
            busy   <= 1'b0;
            done   <= 1'b0;
            adr    <= '0;
            data   <= '0;
            memwen <= 1'b0;
          end
        end

        S_READ: begin
          buf_q  <= resMem;
          sum    <= sum + resMem;
          state  <= S_WRITE;
          adr    <= dst_ptr;
          data   <= resMem;
          memwen <= 1'b1;
        end

        S_WRITE: begin
          src_ptr <= src_next;
          dst_ptr <= dst_next;
          cnt     <= cnt - ONE;
          memwen  <= 1'b0;
          if (cnt == ONE) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            adr   <= '0;
            data  <= '0;
          end else begin
            state <= S_READ;
            adr   <= src_next;
            data  <= buf_q;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          adr    <= '0;
          data   <= '0;
          memwen <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          adr    <= '0;
          data   <= '0;
          memwen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copy.sv
// tb/tb_mem_block_copy.sv - self-checking bench for mem_block_copy with write scoreboard
module tb_mem_block_copy;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  src;
  logic [9:0]  dst;
  logic [9:0]  len;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic [9:0]  adr;
  logic [15:0] data;
  logic        memwen;
  logic [15:0] resMem;

  mem_block_copy #(.AW(10), .DW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .adr    (adr),
    .data   (data),
    .memwen (memwen),
    .resMem (resMem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a bench-side preload port.
  logic [15:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [15:0] pre_d;
  assign resMem = mem[adr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (memwen) mem[adr] <= data;
  end

  logic [15:0] ref_mem [0:1023];
  int          total = 0;
  int          bad = 0;
  int          wr_total = 0;
  int          busy_total = 0;
  bit          sb_on = 1'b1;
  logic [9:0]  exp_adr [$];
  logic [15:0] exp_dat [$];
  logic [15:0] exp_sum [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write and every done pulse is checked in order.
  always @(negedge clk) begin
    if (busy) busy_total++;
    if (memwen) begin
      wr_total++;
      if (sb_on) begin
        if (exp_adr.size() == 0) chk("wr_extra", memwen, 0);
        else begin
          chk("wr_adr", adr, exp_adr.pop_front());
          chk("wr_dat", data, exp_dat.pop_front());
        end
      end
    end
    if (done && sb_on) begin
      if (exp_sum.size() == 0) chk("done_extra", done, 0);
      else chk("sum_done", sum, exp_sum.pop_front());
    end
  end

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = 10'(a); pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic preload_1to10();
    for (int i = 0; i < 10; i++) wr(10 + i, 16'(i + 1));
  endtask

  // Expected writes follow memmove semantics: dst[i] receives the old src[i].
  task automatic do_copy(input int s, input int d, input int l,
                         input int poke, input int ps, input int pd, input int pl);
    logic [15:0] vals [0:1023];
    logic [15:0] es;
    int ws, bs, k, wn, nd, nb;
    bit got, dsc;
    es = 16'h0;
    dsc = (d > s);
    for (int i = 0; i < l; i++) begin
      vals[i] = ref_mem[(s + i) % 1024];
      es = es + vals[i];
    end
    if (!dsc) begin
      for (int i = 0; i < l; i++) begin
        exp_adr.push_back(10'((d + i) % 1024)); exp_dat.push_back(vals[i]);
      end
    end else begin
      for (int i = l - 1; i >= 0; i--) begin
        exp_adr.push_back(10'((d + i) % 1024)); exp_dat.push_back(vals[i]);
      end
    end
    exp_sum.push_back(es);
    for (int i = 0; i < l; i++) ref_mem[(d + i) % 1024] = vals[i];

    @(negedge clk);
    ws = wr_total; bs = busy_total;
    src = 10'(s); dst = 10'(d); len = 10'(l); start = 1'b1;
    k = 0; wn = 0; got = 1'b0;
    while (!got && k < 2 * l + 10) begin
      @(negedge clk);
      k++;
      if (start) start = 1'b0;
      if (memwen) begin
        wn++;
        if (wn == poke) begin
          start = 1'b1; src = 10'(ps); dst = 10'(pd); len = 10'(pl);
        end
      end
      if (done) got = 1'b1;
    end
    chk("timeout", got, 1);
    chk("latency", k, 2 * l + 1);
    chk("writes", wr_total - ws, l);
    chk("busy_cyc", busy_total - bs, 2 * l);
    nd = 0; nb = 0;
    repeat (4) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (done) nd++;
      if (busy) nb++;
    end
    chk("post_done", nd, 0);
    chk("post_busy", nb, 0);
    chk("sb_left", exp_adr.size(), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_memwen", memwen, 0);
    chk("rst_adr", adr, 0);
    chk("rst_data", data, 0);
    chk("rst_sum", sum, 0);
    rst = 1'b0;

    // Basic copy.
    preload_1to10();
    do_copy(10, 100, 10, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) chk("t1_mem", mem[100 + i], i + 1);
    chk("t1_sum", sum, 55);

    // Forward overlap (descending).
    do_copy(10, 12, 8, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) chk("t2_mem", mem[12 + i], i + 1);
    chk("t2_m10", mem[10], 1);
    chk("t2_m11", mem[11], 2);

    // Backward overlap (ascending).
    preload_1to10();
    do_copy(12, 10, 8, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) chk("t3_mem", mem[10 + i], i + 3);
    chk("t3_sum", sum, 52);

    // Zero length, then address wrap.
    do_copy(5, 7, 0, 0, 0, 0, 0);
    chk("t4_sum", sum, 0);
    wr(1022, 16'hAAAA); wr(1023, 16'hBBBB); wr(0, 16'hCCCC);
    do_copy(1022, 500, 3, 0, 0, 0, 0);
    chk("t5_m500", mem[500], 16'hAAAA);
    chk("t5_m501", mem[501], 16'hBBBB);
    chk("t5_m502", mem[502], 16'hCCCC);

    // Start pulsed with new arguments during the third write.
    preload_1to10();
    do_copy(10, 100, 5, 3, 0, 1, 7);
    for (int i = 0; i < 5; i++) chk("t6_mem", mem[100 + i], i + 1);
    chk("t6_sum", sum, 15);

    // src == dst.
    do_copy(10, 10, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("t7_mem", mem[10 + i], i + 1);

    // Asynchronous reset in the middle of a write.
    sb_on = 1'b0;
    @(negedge clk);
    src = 10'd10; dst = 10'd300; len = 10'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!memwen && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_wr", memwen, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_memwen", memwen, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_adr", adr, 0);
    chk("arst_data", data, 0);
    chk("arst_sum", sum, 0);
    @(negedge clk);
    chk("arst_hold_done", done, 0);
    rst = 1'b0;
    sb_on = 1'b1;
    do_copy(10, 200, 2, 0, 0, 0, 0);
    chk("t8_m200", mem[200], 1);
    chk("t8_m201", mem[201], 2);
    chk("t8_sum", sum, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
